prbs_stream_checker: RTL

Synthesizable receiving end of the VIP's PRBS31 stream generator. It accepts words over a valid/ready interface and applies a programmable backpressure pattern. It self-synchronizes to the PRBS31 sequence, then counts words and mismatching words. It sits in the block-level sim top as the DUT-side sink; the monitor reads its counters and status.

---
 rtl/prbs_stream_checker.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/prbs_stream_checker.sv
// prbs_stream_checker: sink for a PRBS31 word stream (b[n] = b[n-31] ^ b[n-28]).
// It applies a programmable ready pattern and self-synchronises to the stream.
// Once locked it counts accepted and mismatching words.
// Optional feature macro: PRBS_CHK_BITERR_EN adds O_BIT_ERR_CNT, a saturating
// count of the bit errors in mismatched words while locked.
module prbs_stream_checker #(
    parameter int P_DATA_W   = 32,
    parameter int P_CNT_W    = 16,
    parameter int P_LOCK_CNT = 4,
    parameter int P_LOSS_CNT = 3
) (
    input  logic                I_CLK,
    input  logic                I_RESET,
    input  logic                I_ENABLE,
    input  logic [7:0]          I_BP_MASK,
    input  logic                I_VALID,
    output logic                O_READY,
    input  logic [P_DATA_W-1:0] I_DATA,
    input  logic                I_CNT_CLR,
    output logic                O_LOCKED,
    output logic                O_ERR,
    output logic [P_CNT_W-1:0]  O_WORD_CNT,
    output logic [P_CNT_W-1:0]  O_ERR_CNT,
    output logic                O_LOSS
`ifdef PRBS_CHK_BITERR_EN
    ,
    output logic [P_CNT_W+7:0]  O_BIT_ERR_CNT
`endif
);

    typedef enum logic [1:0] {IDLE, SYNC, LOCKED} state_t;

    localparam int          SEQ_W     = P_DATA_W + 31;
    localparam logic [3:0]  LOCK_LIM  = 4'(P_LOCK_CNT);
    localparam logic [3:0]  LOSS_LIM  = 4'(P_LOSS_CNT);

    state_t               state_q;
    logic [2:0]           phase_q, phase_d;
    logic                 ready_q, ready_d;
    logic [3:0]           matchCnt_q, lossCnt_q;
    logic [30:0]          ref_q;
    logic                 refValid_q;
    logic [P_CNT_W-1:0]   wordCnt_q, errCnt_q;
    logic                 err_q, lossFlag_q;
    logic [P_DATA_W-1:0]  expWord;
    logic                 accept, wordMatch;
    logic [3:0]           matchInc, lossInc;

    // Ready comes from the registered phase so it never depends on I_VALID.
    always_comb begin
        phase_d = I_ENABLE ? phase_q + 3'd1 : 3'd0;
        ready_d = I_ENABLE & I_BP_MASK[phase_d];
    end

    // Unroll the PRBS recurrence P_DATA_W bits past the 31-bit reference; index 0 is the newest bit.
    always_comb begin
        logic [SEQ_W-1:0] seq;
        seq = '0;
        seq[SEQ_W-1 -: 31] = ref_q;
        for (int t = 31; t < SEQ_W; t++) begin
            seq[SEQ_W-1-t] = seq[SEQ_W-1-(t-31)] ^ seq[SEQ_W-1-(t-28)];
        end
        expWord = seq[P_DATA_W-1:0];
    end

    assign accept    = I_VALID & ready_q;
    assign wordMatch = (I_DATA == expWord);
    assign matchInc  = matchCnt_q + 4'd1;
    assign lossInc   = lossCnt_q + 4'd1;

    // Phase counter and registered ready.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            phase_q <= 3'd0;
            ready_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            ready_q <= ready_d;
        end
    end

    // Sync/lock state machine, reference register and counters. A clear overrides the same-cycle counter updates.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q    <= IDLE;
            matchCnt_q <= '0;
            lossCnt_q  <= '0;
            ref_q      <= '0;
            refValid_q <= 1'b0;
            wordCnt_q  <= '0;
            errCnt_q   <= '0;
            err_q      <= 1'b0;
            lossFlag_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (!I_ENABLE) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q    <= SYNC;
                        matchCnt_q <= '0;
                        refValid_q <= 1'b0;
                    end
                    SYNC: begin
                        if (accept) begin
                            ref_q      <= I_DATA[30:0];
                            refValid_q <= 1'b1;
                            if (refValid_q) begin
                                if (!wordMatch) begin
                                    matchCnt_q <= '0;
                                end else if (matchInc == LOCK_LIM) begin
                                    matchCnt_q <= '0;
                                    lossCnt_q  <= '0;
                                    state_q    <= LOCKED;
                                end else begin
                                    matchCnt_q <= matchInc;
                                end
                            end
                        end
                    end
                    LOCKED: begin
                        if (accept) begin
                            ref_q <= I_DATA[30:0];
                            if (!(&wordCnt_q)) wordCnt_q <= wordCnt_q + 1'b1;
                            if (wordMatch) begin
                                lossCnt_q <= '0;
                            end else begin
                                err_q <= 1'b1;
                                if (!(&errCnt_q)) errCnt_q <= errCnt_q + 1'b1;
                                if (lossInc == LOSS_LIM) begin
                                    lossCnt_q  <= '0;
                                    matchCnt_q <= '0;
                                    lossFlag_q <= 1'b1;
                                    state_q    <= SYNC;
                                end else begin
                                    lossCnt_q <= lossInc;
                                end
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
            if (I_CNT_CLR) begin
                wordCnt_q  <= '0;
                errCnt_q   <= '0;
                lossFlag_q <= 1'b0;
            end
        end
    end

    assign O_READY    = ready_q;
    assign O_LOCKED   = (state_q == LOCKED);
    assign O_ERR      = err_q;
    assign O_WORD_CNT = wordCnt_q;
    assign O_ERR_CNT  = errCnt_q;
    assign O_LOSS     = lossFlag_q;

`ifdef PRBS_CHK_BITERR_EN
    localparam int PC_W = $clog2(P_DATA_W + 1);

    logic [PC_W-1:0]      popCnt;
    logic [P_CNT_W+8:0]   bitSum;
    logic [P_CNT_W+7:0]   bitErrCnt_q;

    // Count the differing bits of the current word against the prediction.
    always_comb begin
        logic [P_DATA_W-1:0] diff;
        diff   = I_DATA ^ expWord;
        popCnt = '0;
        for (int i = 0; i < P_DATA_W; i++) begin
            popCnt = popCnt + PC_W'(diff[i]);
        end
        bitSum = {1'b0, bitErrCnt_q} + {{(P_CNT_W+9-PC_W){1'b0}}, popCnt};
    end

    // Saturating bit-error accumulator, updated alongside the word error counter.
    always_ff @(posedge I_CLK) begin
        if (I_RESET || I_CNT_CLR) begin
            bitErrCnt_q <= '0;
        end else if (I_ENABLE && state_q == LOCKED && accept && !wordMatch) begin
            bitErrCnt_q <= bitSum[P_CNT_W+8] ? '1 : bitSum[P_CNT_W+7:0];
        end
    end

    assign O_BIT_ERR_CNT = bitErrCnt_q;
`endif

endmodule
